// File: rtl/axi_slave_mem.sv
// axi_slave_mem: AXI3-style slave memory responder with independent write and read FSMs.
// Word-addressed 32-bit RAM, single and burst transfers, registered level-then-drop handshakes.
// Optional build macro AXI_SLAVE_RANGE_ERR_EN: flag beats beyond the RAM as SLVERR instead of
// letting the word index wrap.

module axi_slave_mem #(
  parameter int unsigned MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned READ_WAIT = 0
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned Depth      = 1 << MEM_AW;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;

  logic [31:0] mem [Depth];

  w_state_e    w_state_q;
  logic [3:0]  w_id_q;
  logic [31:0] w_addr_q;
  logic [3:0]  w_len_q;
  logic [1:0]  w_size_q;
  logic        w_fixed_q;
  logic [4:0]  w_cnt_q;
  logic        w_err_q;

  r_state_e    r_state_q;
  logic [31:0] r_addr_q;
  logic [3:0]  r_len_q;
  logic [1:0]  r_size_q;
  logic [3:0]  r_cnt_q;
  logic [3:0]  r_wait_q;

  logic              w_beat;
  logic              w_ok;
  logic              r_ok;
  logic [4:0]        w_cnt_next;
  logic              w_mismatch;
  logic [MEM_AW-1:0] w_idx;
  logic [MEM_AW-1:0] r_idx;
  logic              unused_wid;

  function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
    return MEM_AW'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_SLAVE_RANGE_ERR_EN
  function automatic logic in_range(input logic [31:0] a);
    return ((a - BASE_ADDR) >> (MEM_AW + 2)) == 32'd0;
  endfunction

  assign w_ok = in_range(w_addr_q);
  assign r_ok = in_range(r_addr_q);
`else
  assign w_ok = 1'b1;
  assign r_ok = 1'b1;
`endif

  assign w_idx      = word_idx(w_addr_q);
  assign r_idx      = word_idx(r_addr_q);
  assign w_beat     = (w_state_q == WData) && wvalid && wready;
  assign w_cnt_next = w_cnt_q + 5'd1;
  assign w_mismatch = w_cnt_next != ({1'b0, w_len_q} + 5'd1);
  assign unused_wid = ^wid;

  // RAM byte-lane writes; contents deliberately survive reset
  always_ff @(posedge aclk) begin
    if (!areset && w_beat && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wrdata[8*b +: 8];
      end
    end
  end

  // Write path: address capture, data beats, then a held response
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_fixed_q <= 1'b0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (awvalid && awready) begin
            awready   <= 1'b0;
            w_id_q    <= awid;
            w_addr_q  <= awadr;
            w_len_q   <= awlen;
            w_size_q  <= (awsize > 3'd2) ? 2'd2 : awsize[1:0];
            w_fixed_q <= (awburst == 2'b00);
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_state_q <= WData;
          end else begin
            awready <= awvalid && !awready;
          end
        end
        WData: begin
          if (w_beat) begin
            wready  <= 1'b0;
            w_cnt_q <= w_cnt_next;
            if (!w_fixed_q) w_addr_q <= w_addr_q + (32'd1 << w_size_q);
            if (!w_ok) w_err_q <= 1'b1;
            if (wlast) begin
              bvalid    <= 1'b1;
              bid       <= w_id_q;
              bresp     <= (w_mismatch || w_err_q || !w_ok) ? RespSlvErr : RespOkay;
              w_state_q <= WResp;
            end
          end else begin
            wready <= wvalid && !wready;
          end
        end
        WResp: begin
          if (bvalid && bready) begin
            bvalid    <= 1'b0;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Read path: address capture, optional wait, then one beat per two cycles minimum
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_cnt_q   <= '0;
      r_wait_q  <= '0;
      arready   <= 1'b0;
      rid       <= '0;
      rdata     <= '0;
      rresp     <= '0;
      rlast     <= 1'b0;
      rvalid    <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (arvalid && arready) begin
            arready   <= 1'b0;
            rid       <= arid;
            r_addr_q  <= araddr;
            r_len_q   <= arlen;
            r_size_q  <= (arsize > 3'd2) ? 2'd2 : arsize[1:0];
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            r_state_q <= (READ_WAIT == 0) ? RData : RWait;
          end else begin
            arready <= arvalid && !arready;
          end
        end
        RWait: begin
          if (r_wait_q == 4'(READ_WAIT - 1)) r_state_q <= RData;
          else r_wait_q <= r_wait_q + 4'd1;
        end
        RData: begin
          if (!rvalid) begin
            // Registered RAM read: a same-edge write to this word is not yet visible
            rvalid <= 1'b1;
            rdata  <= r_ok ? mem[r_idx] : 32'hDEAD_BEEF;
            rresp  <= r_ok ? RespOkay : RespSlvErr;
            rlast  <= (r_cnt_q == r_len_q);
          end else if (rready) begin
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            r_addr_q <= r_addr_q + (32'd1 << r_size_q);
            r_cnt_q  <= r_cnt_q + 4'd1;
            if (rlast) r_state_q <= RIdle;
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// tb_axi_slave_mem: table-driven bench for axi_slave_mem with write/read response scoreboards.
// A second instance with READ_WAIT=3 exercises the read wait-state timing.

module tb_axi_slave_mem;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset = 1'b1;
  logic [3:0]  awid = '0;
  logic [31:0] awadr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wrdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [3:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b1;

  // Wait-state instance: only its read channel is driven
  logic        w3_awready, w3_wready, w3_bvalid, w3_arready, w3_rlast, w3_rvalid;
  logic [3:0]  w3_bid, w3_rid;
  logic [1:0]  w3_bresp, w3_rresp;
  logic [31:0] w3_rdata;
  logic [31:0] w3_araddr = '0;
  logic        w3_arvalid = 1'b0;

  axi_slave_mem u_dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(4'd0), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  axi_slave_mem #(.READ_WAIT(3)) u_dut_wait (
    .aclk(aclk), .areset(areset),
    .awid(4'd0), .awadr(32'd0), .awlen(4'd0), .awsize(3'd2), .awburst(2'b01),
    .awvalid(1'b0), .awready(w3_awready),
    .wid(4'd0), .wrdata(32'd0), .wstrb(4'd0), .wlast(1'b0), .wvalid(1'b0),
    .wready(w3_wready),
    .bid(w3_bid), .bresp(w3_bresp), .bvalid(w3_bvalid), .bready(1'b1),
    .arid(4'd0), .araddr(w3_araddr), .arlen(4'd0), .arsize(3'd2), .arvalid(w3_arvalid),
    .arready(w3_arready),
    .rid(w3_rid), .rdata(w3_rdata), .rresp(w3_rresp), .rlast(w3_rlast), .rvalid(w3_rvalid),
    .rready(1'b1)
  );

  typedef struct {
    bit               is_wr;
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       strb;
    int               nbeats;
    logic [3:0][31:0] data;   // write data, or expected read data
    logic [1:0]       resp;   // expected bresp / rresp
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t r_q[$];
  bexp_t b_q[$];
  vec_t  vecs[16];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit w, input logic [3:0] id, input logic [31:0] a,
                              input logic [3:0] len, input logic [2:0] sz, input logic [1:0] bu,
                              input logic [3:0] st, input int nb, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] d3, input logic [1:0] resp);
    vec_t v;
    v.is_wr = w; v.id = id; v.addr = a; v.len = len; v.size = sz; v.burst = bu;
    v.strb = st; v.nbeats = nb; v.data = {d3, d2, d1, d0}; v.resp = resp;
    return v;
  endfunction

  // All driver tasks start and end on a negedge
  task automatic send_aw(input vec_t v);
    int t = 0;
    awid = v.id; awadr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
    while (!awready && t < 100) begin @(negedge aclk); t++; end
    check("aw_ready", awready, 1);
    @(negedge aclk);
    awvalid = 1'b0;
    check("aw_pulse", awready, 0);
  endtask

  task automatic send_w(input vec_t v);
    for (int i = 0; i < v.nbeats; i++) begin
      int t = 0;
      wrdata = v.data[i]; wstrb = v.strb; wlast = (i == v.nbeats - 1); wvalid = 1'b1;
      while (!wready && t < 100) begin @(negedge aclk); t++; end
      check("w_ready", wready, 1);
      @(negedge aclk);
      wvalid = 1'b0; wlast = 1'b0;
      check("w_pulse", wready, 0);
    end
  endtask

  task automatic recv_b();
    int t = 0;
    bexp_t e;
    while (!bvalid && t < 100) begin @(negedge aclk); t++; end
    check("b_valid", bvalid, 1);
    check("b_sb_nonempty", b_q.size() != 0, 1);
    if (b_q.size() != 0) begin
      e = b_q.pop_front();
      check("bresp", bresp, e.resp);
      check("bid", bid, e.id);
    end
    @(negedge aclk);
    check("b_drop", bvalid, 0);
  endtask

  task automatic send_ar(input vec_t v, input bit push);
    int t = 0;
    if (push) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        rexp_t e;
        e.data = v.data[i]; e.resp = v.resp; e.last = (i == int'(v.len)); e.id = v.id;
        r_q.push_back(e);
      end
    end
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arvalid = 1'b1;
    while (!arready && t < 100) begin @(negedge aclk); t++; end
    check("ar_ready", arready, 1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("ar_pulse", arready, 0);
  endtask

  task automatic recv_r(input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      int gap = 0;
      rexp_t e;
      while (!rvalid && gap < 100) begin @(negedge aclk); gap++; end
      check("r_valid", rvalid, 1);
      check("r_gap", gap, 1);
      check("r_sb_nonempty", r_q.size() != 0, 1);
      if (r_q.size() != 0) begin
        e = r_q.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", rresp, e.resp);
        check("rlast", rlast, e.last);
        check("rid", rid, e.id);
      end
      @(negedge aclk);
    end
  endtask

  initial begin
    vec_t v;
    int   cnt;

    vecs[0]  = mk(1, 4'h0, 32'h10, 0, 2, 2'b01, 4'hF, 1, 32'hA5A5_1234, 0, 0, 0, 2'b00);
    vecs[1]  = mk(0, 4'h0, 32'h10, 0, 2, 2'b01, 4'hF, 1, 32'hA5A5_1234, 0, 0, 0, 2'b00);
    vecs[2]  = mk(1, 4'h1, 32'h20, 0, 2, 2'b01, 4'hF, 1, 32'hFFFF_FFFF, 0, 0, 0, 2'b00);
    vecs[3]  = mk(1, 4'h2, 32'h20, 0, 2, 2'b01, 4'h5, 1, 32'h0000_0000, 0, 0, 0, 2'b00);
    vecs[4]  = mk(0, 4'h3, 32'h20, 0, 2, 2'b01, 4'hF, 1, 32'hFF00_FF00, 0, 0, 0, 2'b00);
    vecs[5]  = mk(1, 4'h5, 32'h100, 3, 2, 2'b01, 4'hF, 4, 1, 2, 3, 4, 2'b00);
    vecs[6]  = mk(0, 4'h6, 32'h100, 3, 2, 2'b01, 4'hF, 4, 1, 2, 3, 4, 2'b00);
    vecs[7]  = mk(1, 4'h7, 32'h40, 1, 2, 2'b00, 4'hF, 2, 7, 9, 0, 0, 2'b00);
    vecs[8]  = mk(0, 4'h8, 32'h40, 0, 2, 2'b01, 4'hF, 1, 9, 0, 0, 0, 2'b00);
    vecs[9]  = mk(1, 4'hA, 32'h200, 3, 2, 2'b01, 4'hF, 2, 32'hAA, 32'hBB, 0, 0, 2'b10);
    vecs[10] = mk(0, 4'hB, 32'h200, 1, 2, 2'b01, 4'hF, 2, 32'hAA, 32'hBB, 0, 0, 2'b00);
    vecs[11] = mk(1, 4'hC, 32'h0, 0, 2, 2'b01, 4'hF, 1, 32'h1357_9BDF, 0, 0, 0, 2'b00);
`ifdef AXI_SLAVE_RANGE_ERR_EN
    vecs[12] = mk(0, 4'hD, 32'h1000, 0, 2, 2'b01, 4'hF, 1, 32'hDEAD_BEEF, 0, 0, 0, 2'b10);
`else
    vecs[12] = mk(0, 4'hD, 32'h1000, 0, 2, 2'b01, 4'hF, 1, 32'h1357_9BDF, 0, 0, 0, 2'b00);
`endif
    // WRAP burst behaves as INCR; then a size-7 burst clamps to 4-byte steps
    vecs[13] = mk(1, 4'hE, 32'h300, 1, 2, 2'b10, 4'hF, 2, 32'h11, 32'h22, 0, 0, 2'b00);
    vecs[14] = mk(1, 4'hF, 32'h308, 1, 7, 2'b01, 4'hF, 2, 32'h77, 32'h88, 0, 0, 2'b00);
    vecs[15] = mk(0, 4'h4, 32'h300, 3, 2, 2'b01, 4'hF, 4, 32'h11, 32'h22, 32'h77, 32'h88,
                  2'b00);

    repeat (3) @(negedge aclk);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rlast", rlast, 0);
    check("rst_bresp", bresp, 0);
    check("rst_w3_rvalid", w3_rvalid, 0);
    areset = 1'b0;
    @(negedge aclk);

    for (int k = 0; k < 16; k++) begin
      v = vecs[k];
      if (v.is_wr) begin
        bexp_t be;
        be.resp = v.resp; be.id = v.id;
        b_q.push_back(be);
        send_aw(v);
        send_w(v);
        recv_b();
      end else begin
        send_ar(v, 1'b1);
        recv_r(int'(v.len) + 1);
      end
    end

    // READ_WAIT=3: four low cycles between the AR handshake and rvalid
    w3_araddr = 32'h0; w3_arvalid = 1'b1;
    cnt = 0;
    while (!w3_arready && cnt < 100) begin @(negedge aclk); cnt++; end
    check("w3_ar_ready", w3_arready, 1);
    @(negedge aclk);
    w3_arvalid = 1'b0;
    cnt = 0;
    while (!w3_rvalid && cnt < 50) begin cnt++; @(negedge aclk); end
    check("w3_wait_cycles", cnt, 4);
    check("w3_rlast", w3_rlast, 1);
    @(negedge aclk);
    check("w3_r_drop", w3_rvalid, 0);

    // Reset in the middle of a read burst
    rready = 1'b0;
    v = mk(0, 4'h9, 32'h100, 3, 2, 2'b01, 4'hF, 4, 1, 2, 3, 4, 2'b00);
    send_ar(v, 1'b0);
    cnt = 0;
    while (!rvalid && cnt < 100) begin @(negedge aclk); cnt++; end
    check("abort_beat0", rdata, 1);
    @(negedge aclk);
    check("abort_hold", rvalid, 1);
    areset = 1'b1;
    @(negedge aclk);
    check("abort_rvalid", rvalid, 0);
    check("abort_arready", arready, 0);
    check("abort_rlast", rlast, 0);
    areset = 1'b0;
    rready = 1'b1;
    repeat (3) @(negedge aclk);
    check("abort_idle", rvalid, 0);
    v = mk(0, 4'h2, 32'h104, 0, 2, 2'b01, 4'hF, 1, 2, 0, 0, 0, 2'b00);
    send_ar(v, 1'b1);
    recv_r(1);

    check("sb_drained", r_q.size() + b_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
